// File: rtl/prn_frame_sequencer.sv
// prn_frame_sequencer: frames a PRN generator's words into M*N-symbol AXI-Stream frames with gaps, reseeding and stop control.
module prn_frame_sequencer #(
  parameter int DATA_WIDTH = 32,
  parameter int DIM_W = 8
) (
  input  logic                  aclk,
  input  logic                  areset,
  input  logic                  start,
  input  logic                  stop,
  input  logic [DATA_WIDTH-1:0] cfg_seed,
  input  logic [DIM_W-1:0]      cfg_m,
  input  logic [DIM_W-1:0]      cfg_n,
  input  logic [15:0]           cfg_frames,
  input  logic [7:0]            cfg_gap,
  input  logic                  cfg_reseed,
  input  logic [DATA_WIDTH-1:0] prn_data,
  output logic                  prn_load,
  output logic [DATA_WIDTH-1:0] prn_seed,
  output logic                  prn_adv,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tlast,
  output logic                  m_axis_tuser,
  output logic                  busy,
  output logic                  done,
  output logic                  cfg_err,
  output logic [15:0]           frame_cnt
);
  localparam int LW = 2 * DIM_W;
  typedef enum logic [2:0] {IDLE, LOAD, STREAM, GAP, DONE} state_t;
  state_t state, state_nx, after_frame;
  logic [LW-1:0] len, sym_cnt;
  logic [15:0] frames_q, frame_cnt_inc;
  logic [7:0] gap_q, gap_cnt;
  logic reseed_q, stop_pending, stop_eff, hs, last, frame_end, seq_end, accept;
  assign hs = (state == STREAM) && m_axis_tready;
  assign last = sym_cnt == len - LW'(1);
  assign frame_end = hs && last;
  assign stop_eff = stop_pending || stop;
  assign frame_cnt_inc = frame_cnt + 16'd1;
  assign seq_end = ((frames_q != 16'd0) && (frame_cnt_inc == frames_q)) || stop_eff;
  assign after_frame = reseed_q ? LOAD : STREAM;
  assign accept = (state == IDLE) && start && (cfg_m != '0) && (cfg_n != '0);
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = accept ? LOAD : IDLE;
      LOAD:    state_nx = stop_eff ? DONE : STREAM;
      STREAM:  state_nx = !frame_end ? STREAM : seq_end ? DONE : (gap_q == 8'd0) ? after_frame : GAP;
      GAP:     state_nx = (gap_cnt != 8'd0) ? GAP : stop_eff ? DONE : after_frame;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge aclk) begin
    if (areset) begin
      state <= IDLE;
      len <= '0;
      sym_cnt <= '0;
      frames_q <= '0;
      gap_q <= '0;
      gap_cnt <= '0;
      reseed_q <= 1'b0;
      stop_pending <= 1'b0;
      cfg_err <= 1'b0;
      frame_cnt <= '0;
      prn_seed <= '0;
    end else begin
      state <= state_nx;
      cfg_err <= (state == IDLE) && start && ((cfg_m == '0) || (cfg_n == '0));
      stop_pending <= (state == IDLE) ? 1'b0 : stop_pending || stop;
      sym_cnt <= ((state != STREAM) || frame_end) ? '0 : hs ? sym_cnt + LW'(1) : sym_cnt;
      gap_cnt <= (state == GAP) ? gap_cnt - 8'd1 : gap_q - 8'd1;
      if (frame_end) frame_cnt <= frame_cnt_inc;
      if (accept) begin
        len <= LW'(cfg_m) * LW'(cfg_n);
        frames_q <= cfg_frames;
        gap_q <= cfg_gap;
        reseed_q <= cfg_reseed;
        prn_seed <= cfg_seed;
        frame_cnt <= '0;
      end
    end
  end
  assign m_axis_tvalid = state == STREAM;
  assign m_axis_tdata = prn_data;
  assign m_axis_tlast = m_axis_tvalid && last;
  assign m_axis_tuser = m_axis_tvalid && (sym_cnt == '0);
  assign prn_load = state == LOAD;
  assign prn_adv = hs;
  assign busy = state != IDLE;
  assign done = state == DONE;
endmodule

// File: tb/tb_prn_frame_sequencer.sv
// tb_prn_frame_sequencer: directed scenarios with a queue scoreboard checked by a negedge monitor.
module tb_prn_frame_sequencer;
  logic clk = 0, areset = 1, start = 0, stop = 0, cfg_reseed = 0, tready = 1;
  logic [31:0] cfg_seed = 0, prn_data, prn_seed, tdata, word;
  logic [7:0] cfg_m = 0, cfg_n = 0, cfg_gap = 0;
  logic [15:0] cfg_frames = 0, frame_cnt;
  logic prn_load, prn_adv, tvalid, tlast, tuser, busy, done, cfg_err;
  int total = 0, bad = 0, cyc = 0, loads = 0, advs = 0, done_cnt = 0, done_cyc = 0, last_cyc = 0;
  bit done_seen = 0, stall_prev = 0;
  logic [31:0] stall_data;
  logic [33:0] sb[$];
  int beat_cyc[$];
  prn_frame_sequencer dut (
    .aclk(clk), .areset(areset), .start(start), .stop(stop), .cfg_seed(cfg_seed),
    .cfg_m(cfg_m), .cfg_n(cfg_n), .cfg_frames(cfg_frames), .cfg_gap(cfg_gap),
    .cfg_reseed(cfg_reseed), .prn_data(prn_data), .prn_load(prn_load), .prn_seed(prn_seed),
    .prn_adv(prn_adv), .m_axis_tdata(tdata), .m_axis_tvalid(tvalid), .m_axis_tready(tready),
    .m_axis_tlast(tlast), .m_axis_tuser(tuser), .busy(busy), .done(done), .cfg_err(cfg_err),
    .frame_cnt(frame_cnt)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  // External generator stand-in: counts up from the seed so expected words are seed+k.
  always_ff @(posedge clk) if (prn_load) word <= prn_seed; else if (prn_adv) word <= word + 32'd1;
  assign prn_data = word;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  always @(negedge clk) begin
    if (!areset) begin
      if (tvalid && tready) begin
        if (sb.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_beat: got data %0h with empty scoreboard", tdata);
        end else chk("beat", {tlast, tuser, tdata}, sb.pop_front());
        beat_cyc.push_back(cyc);
        if (tlast) last_cyc = cyc;
      end
      if (stall_prev && tvalid) chk("stall_hold", tdata, stall_data);
      stall_prev = tvalid && !tready;
      stall_data = tdata;
      if (prn_load) begin loads++; chk("load_adv_excl", prn_adv, 0); end
      if (prn_adv) advs++;
      if (done) begin done_cnt++; done_seen = 1; done_cyc = cyc; end
    end
  end
  task automatic clr();
    loads = 0; advs = 0; done_cnt = 0; done_seen = 0; last_cyc = 0;
    beat_cyc.delete();
  endtask
  task automatic tick(); @(posedge clk); #1; endtask
  task automatic push_beats(input logic [31:0] seed, input int n, input int len);
    for (int i = 0; i < n; i++)
      sb.push_back({((i % len) == len - 1) ? 1'b1 : 1'b0, ((i % len) == 0) ? 1'b1 : 1'b0, seed + 32'(i)});
  endtask
  task automatic go(input logic [31:0] seed, input int m, input int n, input int fr, input int gap, input bit rs);
    clr();
    cfg_seed = seed; cfg_m = 8'(m); cfg_n = 8'(n); cfg_frames = 16'(fr); cfg_gap = 8'(gap); cfg_reseed = rs;
    start = 1;
    tick();
    start = 0;
    cfg_m = 8'hff; cfg_n = 8'hff; cfg_frames = 16'd7; cfg_gap = 8'd9; cfg_seed = 32'hdead;
  endtask
  task automatic wait_done(input string name);
    for (int i = 0; i < 2000 && !done_seen; i++) @(posedge clk);
    #1;
    if (!done_seen) begin
      total++; bad++;
      $display("FAIL %s_timeout: got no done expected done pulse", name);
    end
    tick(); tick();
  endtask
  initial begin
    logic [4:0] pat;
    repeat (3) tick();
    areset = 0;
    chk("rst_busy", busy, 0);
    chk("rst_tvalid", tvalid, 0);
    chk("rst_frame_cnt", frame_cnt, 0);
    chk("rst_prn_seed", prn_seed, 0);
    chk("rst_done", done, 0);
    // Single reseeded frame of 4x2.
    push_beats(32'd100, 8, 8);
    go(32'd100, 4, 2, 1, 0, 1);
    chk("t1_seed", prn_seed, 100);
    wait_done("t1");
    chk("t1_loads", loads, 1);
    chk("t1_advs", advs, 8);
    chk("t1_done_cnt", done_cnt, 1);
    chk("t1_done_lat", done_cyc - last_cyc, 1);
    chk("t1_frame_cnt", frame_cnt, 1);
    chk("t1_busy", busy, 0);
    chk("t1_sb_empty", sb.size(), 0);
    // Three 2x2 frames, gap 3, PRN continues without reload.
    push_beats(32'd200, 12, 4);
    go(32'd200, 2, 2, 3, 3, 0);
    wait_done("t2");
    chk("t2_beats", beat_cyc.size(), 12);
    chk("t2_contig", beat_cyc[3] - beat_cyc[0], 3);
    chk("t2_gap1", beat_cyc[4] - beat_cyc[3], 4);
    chk("t2_gap2", beat_cyc[8] - beat_cyc[7], 4);
    chk("t2_loads", loads, 1);
    chk("t2_frame_cnt", frame_cnt, 3);
    chk("t2_sb_empty", sb.size(), 0);
    // Backpressure on a 3x1 frame.
    pat = 5'b11001;
    push_beats(32'd300, 3, 3);
    go(32'd300, 3, 1, 1, 0, 1);
    tick();
    for (int k = 0; k < 5; k++) begin tready = pat[k]; tick(); end
    tready = 1;
    wait_done("t3");
    chk("t3_advs", advs, 3);
    chk("t3_frame_cnt", frame_cnt, 1);
    chk("t3_sb_empty", sb.size(), 0);
    // Continuous 1x1 frames stopped on beat 5.
    push_beats(32'd400, 6, 1);
    go(32'd400, 1, 1, 0, 0, 0);
    repeat (6) tick();
    stop = 1;
    tick();
    stop = 0;
    wait_done("t4");
    chk("t4_frame_cnt", frame_cnt, 6);
    chk("t4_loads", loads, 1);
    chk("t4_done_lat", done_cyc - last_cyc, 1);
    chk("t4_sb_empty", sb.size(), 0);
    // Zero dimension is rejected.
    clr();
    cfg_m = 0; cfg_n = 2;
    start = 1;
    tick();
    start = 0;
    chk("t5_cfg_err", cfg_err, 1);
    chk("t5_busy", busy, 0);
    tick();
    chk("t5_cfg_err_pulse", cfg_err, 0);
    chk("t5_busy2", busy, 0);
    // Reset during beat 3 of an 8-beat frame.
    push_beats(32'd500, 3, 8);
    go(32'd500, 4, 2, 1, 0, 1);
    repeat (4) tick();
    areset = 1;
    tick();
    chk("t6_tvalid", tvalid, 0);
    chk("t6_busy", busy, 0);
    chk("t6_frame_cnt", frame_cnt, 0);
    chk("t6_prn_seed", prn_seed, 0);
    areset = 0;
    repeat (20) tick();
    chk("t6_no_done", done_cnt, 0);
    chk("t6_sb_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
